// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: drives a 1-cycle registered instruction memory and presents words to decode.
// Zero-bubble branch redirect; a decode stall re-issues the held address so data stays stable until accepted.
module fetch_controller #(
  parameter int ADDR_WIDTH  = 10,
  parameter int INSTR_WIDTH = 12,
  parameter int RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   reset_fetch,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic                   branch_valid,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [ADDR_WIDTH-1:0]  instruction_addr_pc,
  input  logic [INSTR_WIDTH-1:0] mem_instruction,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   fetch_busy,
  output logic [15:0]            fetch_count,
  output logic                   pc_wrapped
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_TOP = '1;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pc_fetch;
  logic [ADDR_WIDTH-1:0] pc_pending;
  logic                  pending_valid;

  logic                  running;
  logic                  stall;
  logic                  transfer;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_inc;

  assign running = (state == RUN);
  assign stall   = pending_valid & ~instr_ready;

  // Branch beats stall: a redirected stream drops the held word.
  always_comb begin
    addr = pc_fetch;
    if (running) begin
      if (branch_valid) begin
        addr = branch_target;
      end else if (stall) begin
        addr = pc_pending;
      end
    end
  end

  assign addr_inc            = addr + PC_ONE;
  assign instruction_addr_pc = addr;
  assign instr_valid         = running & pending_valid & ~branch_valid;
  assign transfer            = instr_valid & instr_ready;
  assign instr_data          = mem_instruction;
  assign instr_pc            = pc_pending;
  assign fetch_busy          = running;

  always_ff @(posedge clk) begin
    if (reset_fetch) begin
      state         <= IDLE;
      pc_fetch      <= PC_RST;
      pc_pending    <= PC_RST;
      pending_valid <= 1'b0;
      fetch_count   <= 16'd0;
      pc_wrapped    <= 1'b0;
    end else begin
      if (transfer && (fetch_count != 16'hFFFF)) begin
        fetch_count <= fetch_count + 16'd1;
      end
      case (state)
        RUN: begin
          if (halt_req) begin
            // Resume point is whatever would have been fetched this cycle.
            state         <= HALT;
            pending_valid <= 1'b0;
            pc_fetch      <= addr;
          end else begin
            pc_pending    <= addr;
            pending_valid <= 1'b1;
            pc_fetch      <= addr_inc;
            if (addr == PC_TOP) begin
              pc_wrapped <= 1'b1;
            end
          end
        end
        default: begin
          // Outside RUN addr is pc_fetch, so start issues the resume point directly.
          if (start) begin
            state         <= RUN;
            pc_pending    <= pc_fetch;
            pending_valid <= 1'b1;
            pc_fetch      <= addr_inc;
            if (pc_fetch == PC_TOP) begin
              pc_wrapped <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed and randomized checks of fetch_controller against a stream-level reference model.
module tb_fetch_controller;

  localparam int AW    = 10;
  localparam int IW    = 12;
  localparam int RPC   = 0;
  localparam int TOP   = (1 << AW) - 1;
  localparam int NRAND = 3000;

  logic          clk;
  logic          reset_fetch;
  logic          start;
  logic          halt_req;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic [AW-1:0] instruction_addr_pc;
  logic [IW-1:0] mem_instruction;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          fetch_busy;
  logic [15:0]   fetch_count;
  logic          pc_wrapped;

  int total;
  int bad;

  // Reference model: running flag, word on the output (-1 if none), next sequential / resume pc.
  bit m_run;
  int m_cur;
  int m_next;
  int m_count;
  bit m_wrap;

  fetch_controller #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(RPC)) dut (
    .clk                 (clk),
    .reset_fetch         (reset_fetch),
    .start               (start),
    .halt_req            (halt_req),
    .branch_valid        (branch_valid),
    .branch_target       (branch_target),
    .instruction_addr_pc (instruction_addr_pc),
    .mem_instruction     (mem_instruction),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .instr_data          (instr_data),
    .instr_pc            (instr_pc),
    .fetch_busy          (fetch_busy),
    .fetch_count         (fetch_count),
    .pc_wrapped          (pc_wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem_word(input int a);
    return IW'((a * 29 + 53) ^ (a >> 2));
  endfunction

  always @(posedge clk) mem_instruction <= mem_word(int'(instruction_addr_pc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs before the edge, then advance the model.
  task automatic cyc(input logic st, input logic hr, input logic bv, input int bt,
                     input logic rdy, input logic rst, input bit chk);
    bit ev;
    int ea;
    start         = st;
    halt_req      = hr;
    branch_valid  = bv;
    branch_target = AW'(bt);
    instr_ready   = rdy;
    reset_fetch   = rst;
    #4;
    ev = m_run && (m_cur >= 0) && !bv;
    if (!m_run)                     ea = m_next;
    else if (bv)                    ea = bt;
    else if ((m_cur >= 0) && !rdy)  ea = m_cur;
    else                            ea = m_next;
    if (chk) begin
      check("valid", instr_valid, ev);
      check("busy", fetch_busy, m_run);
      check("addr", instruction_addr_pc, ea);
      check("count", fetch_count, m_count);
      check("wrapped", pc_wrapped, m_wrap);
      if (ev) begin
        check("pc", instr_pc, m_cur);
        check("data", instr_data, mem_word(m_cur));
      end
    end
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_cur = -1; m_next = RPC; m_count = 0; m_wrap = 0;
    end else if (!m_run) begin
      if (st) begin
        m_run = 1;
        m_cur = m_next;
        if (m_next == TOP) m_wrap = 1;
        m_next = (m_next + 1) % (TOP + 1);
      end
    end else begin
      if (ev && rdy && (m_count < 65535)) m_count++;
      if (hr) begin
        m_run = 0; m_cur = -1; m_next = ea;
      end else begin
        m_cur = ea;
        if (ea == TOP) m_wrap = 1;
        m_next = (ea + 1) % (TOP + 1);
      end
    end
    #1;
  endtask

  initial begin
    total = 0; bad = 0;
    m_run = 0; m_cur = -1; m_next = RPC; m_count = 0; m_wrap = 0;
    start = 0; halt_req = 0; branch_valid = 0; branch_target = '0;
    instr_ready = 0; reset_fetch = 1;

    cyc(0, 0, 0, 0, 1, 1, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_busy", fetch_busy, 0);
    check("rst_addr", instruction_addr_pc, RPC);

    // Sequential run
    cyc(1, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      check("seq_pc", instr_pc, i);
      cyc(0, 0, 0, 0, 1, 0, 1);
    end
    check("seq_count", fetch_count, 4);

    // Stall at pc 5
    cyc(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("stall_pc", instr_pc, 5);
      check("stall_addr", instruction_addr_pc, 5);
    end
    cyc(0, 0, 0, 0, 1, 0, 1);
    check("post_stall_pc", instr_pc, 6);

    // Branch at pc 7, then branch during a stall
    cyc(0, 0, 0, 0, 1, 0, 1);
    check("pre_branch_pc", instr_pc, 7);
    cyc(0, 0, 1, 'h200, 1, 0, 1);
    check("branch_pc", instr_pc, 'h200);
    cyc(0, 0, 0, 0, 1, 0, 1);
    check("branch_next_pc", instr_pc, 'h201);
    cyc(0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 'h300, 0, 0, 1);
    check("stall_branch_pc", instr_pc, 'h300);
    cyc(0, 0, 0, 0, 1, 0, 1);
    check("stall_branch_next", instr_pc, 'h301);

    // Halt with the word accepted, resume after 4 cycles
    cyc(0, 0, 1, 8, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 1);
    check("halt_at_pc", instr_pc, 9);
    cyc(0, 1, 0, 0, 1, 0, 1);
    check("halt_valid", instr_valid, 0);
    check("halt_busy", fetch_busy, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 1, 0, 1);
    check("resume_pc", instr_pc, 10);
    check("resume_valid", instr_valid, 1);
    // Halt with the word not accepted: it comes back
    cyc(0, 1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 1);
    cyc(0, 1, 0, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 1, 0, 1);
    check("represent_pc", instr_pc, 10);

    // Wrap past the top address
    cyc(0, 0, 1, TOP - 1, 1, 0, 1);
    check("wrap_pre", pc_wrapped, 0);
    cyc(0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 1);
    check("wrap_pc", instr_pc, 0);
    cyc(0, 0, 0, 0, 1, 0, 1);
    check("wrap_flag", pc_wrapped, 1);
    cyc(0, 0, 0, 0, 1, 1, 1);
    check("wrap_rst", pc_wrapped, 0);
    cyc(1, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1, 0, 1);
    check("branch0_nowrap", pc_wrapped, 0);

    // Reset in the middle of a stalled run
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_busy", fetch_busy, 0);
    check("mid_rst_count", fetch_count, 0);
    check("mid_rst_addr", instruction_addr_pc, RPC);

    // Randomized traffic
    for (int i = 0; i < NRAND; i++) begin
      logic st, hr, bv, rdy, rst;
      int bt;
      st  = ($urandom_range(0, 7) == 0);
      hr  = ($urandom_range(0, 15) == 0);
      bv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      case ($urandom_range(0, 3))
        0:       bt = TOP;
        1:       bt = TOP - 1;
        2:       bt = 0;
        default: bt = int'($urandom_range(0, TOP));
      endcase
      cyc(st, hr, bv, bt, rdy, rst, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
